alu_op_issue: RTL

//  Decode/issue stage feeding the ALU sub-units (adder, Logic, shifter, comparator).

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_op_decode.sv | 87 ++++++++
 rtl/alu_op_issue.sv | 79 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU unit/control codes, RV64 opcodes and decoded-op struct
package alu_pkg;

    localparam int ALU_XLEN   = 64;
    localparam int ALU_CTRL_W = 4;

    typedef enum logic [1:0] {
        UNIT_ADD   = 2'd0,
        UNIT_LOGIC = 2'd1,
        UNIT_SHIFT = 2'd2,
        UNIT_CMP   = 2'd3
    } alu_unit_e;

    localparam logic [ALU_CTRL_W-1:0] CTRL_ADD  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SUB  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] CTRL_AND  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] CTRL_XOR  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] CTRL_OR   = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SLL  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SRL  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SRA  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SLT  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SLTU = 4'd1;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_unit_e                unit;
        logic [ALU_CTRL_W-1:0]    ctrl;
        logic [ALU_XLEN-1:0]      src1;
        logic [ALU_XLEN-1:0]      src2;
        logic                     word;
        logic                     illegal;
    } alu_op_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV64I integer instruction to ALU op decode
import alu_pkg::*;

module alu_op_decode (
    input  logic [31:0]          i_inst,
    input  logic [ALU_XLEN-1:0]  i_rs1,
    input  logic [ALU_XLEN-1:0]  i_rs2,
    output alu_op_t              o_op
);

    logic [6:0]            w_opc;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic                  w_is_reg;
    logic                  w_is_imm;
    logic                  w_f7_ok;
    logic                  w_f3_word;
    logic                  w_legal;
    alu_unit_e             w_unit;
    logic [ALU_CTRL_W-1:0] w_ctrl;
    logic [ALU_XLEN-1:0]   w_imm;

    assign w_opc     = i_inst[6:0];
    assign w_f3      = i_inst[14:12];
    assign w_f7      = i_inst[31:25];
    assign w_is_reg  = (w_opc == OPC_OP)     || (w_opc == OPC_OP_32);
    assign w_is_imm  = (w_opc == OPC_OP_IMM) || (w_opc == OPC_OP_IMM_32);
    assign w_f3_word = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign w_imm     = {{(ALU_XLEN-12){i_inst[31]}}, i_inst[31:20]};
    // The alternate funct7 only selects SUB/SRA, so it is meaningful for f3 000/101 alone
    assign w_f7_ok   = (w_f7 == F7_BASE) ||
                       ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));

    always_comb begin
        w_legal = 1'b0;
        case (w_opc)
            OPC_OP:        w_legal = w_f7_ok;
            OPC_OP_32:     w_legal = w_f3_word && w_f7_ok;
            OPC_OP_IMM: begin
                case (w_f3)
                    3'b001:  w_legal = (i_inst[31:26] == 6'b000000);
                    3'b101:  w_legal = (i_inst[31:26] == 6'b000000) ||
                                       (i_inst[31:26] == 6'b010000);
                    default: w_legal = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: w_legal = (w_f3 == 3'b000) || (w_f3_word && w_f7_ok);
            default:       w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_unit = UNIT_ADD;
        w_ctrl = CTRL_ADD;
        case (w_f3)
            3'b000: begin
                w_unit = UNIT_ADD;
                w_ctrl = (w_is_reg && (w_f7 == F7_ALT)) ? CTRL_SUB : CTRL_ADD;
            end
            3'b001: begin w_unit = UNIT_SHIFT; w_ctrl = CTRL_SLL;  end
            3'b010: begin w_unit = UNIT_CMP;   w_ctrl = CTRL_SLT;  end
            3'b011: begin w_unit = UNIT_CMP;   w_ctrl = CTRL_SLTU; end
            3'b100: begin w_unit = UNIT_LOGIC; w_ctrl = CTRL_XOR;  end
            3'b101: begin
                w_unit = UNIT_SHIFT;
                w_ctrl = i_inst[30] ? CTRL_SRA : CTRL_SRL;
            end
            3'b110: begin w_unit = UNIT_LOGIC; w_ctrl = CTRL_OR;   end
            default: begin w_unit = UNIT_LOGIC; w_ctrl = CTRL_AND; end
        endcase
    end

    always_comb begin
        o_op = '0;
        if (w_legal) begin
            o_op.unit    = w_unit;
            o_op.ctrl    = w_ctrl;
            o_op.src1    = i_rs1;
            o_op.src2    = w_is_imm ? w_imm : i_rs2;
            o_op.word    = (w_opc == OPC_OP_32) || (w_opc == OPC_OP_IMM_32);
            o_op.illegal = 1'b0;
        end else begin
            o_op.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - ALU issue stage: decode plus 2-entry skid buffer handshake
import alu_pkg::*;

module alu_op_issue #(
    parameter int XLEN   = ALU_XLEN,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_unit,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_src1,
    output logic [XLEN-1:0]   out_src2,
    output logic              out_word,
    output logic              out_illegal
);

    alu_op_t r_m_op;
    alu_op_t r_s_op;
    logic    r_m_valid;
    logic    r_s_valid;
    alu_op_t w_dec_op;
    logic    w_accept;
    logic    w_consume;

    alu_op_decode u_decode (
        .i_inst (in_inst),
        .i_rs1  (in_rs1),
        .i_rs2  (in_rs2),
        .o_op   (w_dec_op)
    );

    // Ready depends only on skid occupancy, so it never combinationally follows out_ready
    assign in_ready  = !r_s_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_m_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m_op    <= '0;
            r_s_op    <= '0;
        end else if (w_consume) begin
            if (r_s_valid) begin
                r_m_op    <= r_s_op;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_m_op    <= w_dec_op;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (!r_m_valid) begin
            if (w_accept) begin
                r_m_op    <= w_dec_op;
                r_m_valid <= 1'b1;
            end
        end else if (w_accept) begin
            r_s_op    <= w_dec_op;
            r_s_valid <= 1'b1;
        end
    end

    assign out_valid   = r_m_valid;
    assign out_unit    = r_m_op.unit;
    assign out_ctrl    = r_m_op.ctrl;
    assign out_src1    = r_m_op.src1;
    assign out_src2    = r_m_op.src2;
    assign out_word    = r_m_op.word;
    assign out_illegal = r_m_op.illegal;

endmodule
